// File: rtl/iserdes_check_pkg.sv
// iserdes_check_pkg
// Shared definitions for the ISERDESE2 word-alignment checker:
//   - state_t         : alignment FSM states
//   - DEFAULT_PATTERN : training word produced by the matching OSERDESE2 test
//   - cnt_width()     : bits needed to hold a counter value 0..max_val
package iserdes_check_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        SETTLE = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Bit 0 is the first bit on the wire.
    localparam logic [7:0] DEFAULT_PATTERN = 8'h53;

    // Width of a counter that must represent every value from 0 to max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/iserdes_align_checker.sv
// iserdes_align_checker
// Aligns the parallel word of a master ISERDESE2 to a known training pattern
// by pulsing BITSLIP, then monitors every word once locked.
//
// Ports:
//   clk        in   CLKDIV-rate clock (same as ISERDESE2 CLKDIV)
//   rst        in   asynchronous active-high reset
//   rx_data    in   8-bit ISERDESE2 Q word, bit 0 = earliest bit
//   bitslip    out  one-cycle pulse to ISERDESE2 BITSLIP
//   aligned    out  high while locked
//   slip_count out  number of slips issued, modulo 8
//   err_count  out  saturating count of bad words while locked
//   err_pulse  out  one-cycle pulse per bad word while locked
//   locked_led out  ~aligned, for active-low board LEDs
//
// Build option: define ISERDES_CHECK_ERRCNT_EN to include the error counter
// and error pulse. Without it both outputs are tied low; lock and loss
// behaviour is identical.
module iserdes_align_checker
    import iserdes_check_pkg::*;
#(
    parameter logic [7:0] PATTERN       = DEFAULT_PATTERN,
    parameter int         MATCH_COUNT   = 16,
    parameter int         LOSS_COUNT    = 4,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    output logic             bitslip,
    output logic             aligned,
    output logic [2:0]       slip_count,
    output logic [ERR_W-1:0] err_count,
    output logic             err_pulse,
    output logic             locked_led
);

    localparam int MW = cnt_width(MATCH_COUNT);
    localparam int LW = cnt_width(LOSS_COUNT);
    localparam int SW = cnt_width(SETTLE_CYCLES);

    state_t          state_r;
    logic [7:0]      rx_q_r;
    // rx_q_r holds only the reset value until the first capture; comparing
    // that stale value would trigger a spurious slip on a healthy link.
    logic            rx_vld_r;
    logic [MW-1:0]   match_cnt_r;
    logic [LW-1:0]   miss_cnt_r;
    logic [SW-1:0]   settle_cnt_r;
    logic            word_ok_s;

    assign word_ok_s = (rx_q_r == PATTERN);

    // Input capture, alignment FSM and all registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= SEARCH;
            rx_q_r       <= 8'h00;
            rx_vld_r     <= 1'b0;
            match_cnt_r  <= {MW{1'b0}};
            miss_cnt_r   <= {LW{1'b0}};
            settle_cnt_r <= {SW{1'b0}};
            bitslip      <= 1'b0;
            aligned      <= 1'b0;
            locked_led   <= 1'b1;
            slip_count   <= 3'd0;
`ifdef ISERDES_CHECK_ERRCNT_EN
            err_count    <= {ERR_W{1'b0}};
            err_pulse    <= 1'b0;
`endif
        end else begin
            rx_q_r   <= rx_data;
            rx_vld_r <= 1'b1;
            bitslip  <= 1'b0;
`ifdef ISERDES_CHECK_ERRCNT_EN
            err_pulse <= 1'b0;
`endif
            case (state_r)
                SEARCH: begin
                    if (rx_vld_r) begin
                        if (word_ok_s) begin
                            if (match_cnt_r == MW'(MATCH_COUNT - 1)) begin
                                state_r     <= LOCKED;
                                match_cnt_r <= {MW{1'b0}};
                                aligned     <= 1'b1;
                                locked_led  <= 1'b0;
                            end else begin
                                match_cnt_r <= match_cnt_r + MW'(1);
                            end
                        end else begin
                            // Registered pulse: bitslip is high for the whole SLIP cycle.
                            state_r     <= SLIP;
                            match_cnt_r <= {MW{1'b0}};
                            bitslip     <= 1'b1;
                            slip_count  <= slip_count + 3'd1;
                        end
                    end else begin
                        match_cnt_r <= {MW{1'b0}};
                    end
                end
                SLIP: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= SW'(SETTLE_CYCLES);
                end
                SETTLE: begin
                    // Words are still shifting inside the ISERDESE2; ignore them.
                    if (settle_cnt_r == {SW{1'b0}}) begin
                        state_r <= SEARCH;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - SW'(1);
                    end
                end
                LOCKED: begin
                    if (word_ok_s) begin
                        miss_cnt_r <= {LW{1'b0}};
                    end else begin
`ifdef ISERDES_CHECK_ERRCNT_EN
                        err_pulse <= 1'b1;
                        if (err_count != {ERR_W{1'b1}}) begin
                            err_count <= err_count + ERR_W'(1);
                        end else begin
                            err_count <= err_count;
                        end
`endif
                        if (miss_cnt_r == LW'(LOSS_COUNT - 1)) begin
                            state_r     <= SEARCH;
                            miss_cnt_r  <= {LW{1'b0}};
                            match_cnt_r <= {MW{1'b0}};
                            aligned     <= 1'b0;
                            locked_led  <= 1'b1;
                        end else begin
                            miss_cnt_r <= miss_cnt_r + LW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= SEARCH;
                end
            endcase
        end
    end

`ifndef ISERDES_CHECK_ERRCNT_EN
    assign err_count = {ERR_W{1'b0}};
    assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_iserdes_align_checker.sv
module tb_iserdes_align_checker;

    localparam logic [7:0] PAT = 8'h53;
`ifdef ISERDES_CHECK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        bitslip, aligned, err_pulse, locked_led;
    logic [2:0]  slip_count;
    logic [15:0] err_count;
    // Second instance with a narrow error counter so saturation is reachable.
    logic        s_bitslip, s_aligned, s_err_pulse, s_locked_led;
    logic [2:0]  s_slip_count;
    logic [3:0]  s_err_count;

    int checks = 0;
    int failures = 0;
    int err_pulses, sat_pulses, slip_pulses, cycle;

    iserdes_align_checker dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .bitslip(bitslip),
        .aligned(aligned), .slip_count(slip_count), .err_count(err_count),
        .err_pulse(err_pulse), .locked_led(locked_led)
    );

    iserdes_align_checker #(.ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .rx_data(rx_data), .bitslip(s_bitslip),
        .aligned(s_aligned), .slip_count(s_slip_count), .err_count(s_err_count),
        .err_pulse(s_err_pulse), .locked_led(s_locked_led)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        int m;
        m = ((k % 8) + 8) % 8;
        return (v << m) | (v >> (8 - m));
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] v;
        v = 8'($urandom);
        while (v == PAT) v = 8'($urandom);
        return v;
    endfunction

    function automatic int exp_err(input int n);
        return ERR_EN ? n : 0;
    endfunction

    function automatic int exp_sat(input int n);
        return ERR_EN ? ((n > 15) ? 15 : n) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (err_pulse) err_pulses++;
        if (s_err_pulse) sat_pulses++;
        if (bitslip) slip_pulses++;
    endtask

    task automatic clear_counts();
        err_pulses = 0; sat_pulses = 0; slip_pulses = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rx_data = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reset, feed the pattern, return the number of edges until aligned.
    task automatic lock_link(output int n);
        apply_reset();
        clear_counts();
        rx_data = PAT;
        n = 0;
        while (n < 40 && !aligned) begin
            step();
            n++;
        end
        clear_counts();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_data = 8'h53;
        #2;
        checks++;
        if (bitslip !== 1'b0 || aligned !== 1'b0 || slip_count !== 3'd0 ||
            err_count !== 16'h0000 || err_pulse !== 1'b0 || locked_led !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: got bs=%b al=%b sc=%0d ec=%0d ep=%b led=%b required 0 0 0 0 0 1",
                     bitslip, aligned, slip_count, err_count, err_pulse, locked_led);
        end
        step();
        step();
        checks++;
        if (aligned !== 1'b0 || bitslip !== 1'b0 || locked_led !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: got al=%b bs=%b led=%b required 0 0 1", aligned, bitslip, locked_led);
        end
    endtask

    task automatic test_lock_constant();
        int n;
        apply_reset();
        clear_counts();
        rx_data = PAT;
        n = 0;
        while (n < 40 && !aligned) begin
            step();
            n++;
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL lock_latency: got %0d edges required 17", n);
        end
        checks++;
        if (slip_pulses != 0 || slip_count !== 3'd0) begin
            failures++;
            $display("FAIL lock_no_slip: got pulses=%0d slip_count=%0d required 0 0", slip_pulses, slip_count);
        end
        checks++;
        if (locked_led !== 1'b0) begin
            failures++;
            $display("FAIL lock_led: got %b required 0", locked_led);
        end
    endtask

    // Link starts rotated by r; each bitslip pulse rotates the received word back by one.
    task automatic test_slip(input int r);
        int rot, last, min_gap;
        apply_reset();
        clear_counts();
        rot = r;
        rx_data = rotl(PAT, rot);
        last = -100;
        min_gap = 1000;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bitslip) begin
                if (cycle - last < min_gap) min_gap = cycle - last;
                last = cycle;
                rot = rot - 1;
                rx_data = rotl(PAT, rot);
            end
            if (aligned) break;
        end
        checks++;
        if (aligned !== 1'b1) begin
            failures++;
            $display("FAIL slip_lock r=%0d: got aligned=%b required 1", r, aligned);
        end
        checks++;
        if (slip_pulses != r) begin
            failures++;
            $display("FAIL slip_pulses r=%0d: got %0d required %0d", r, slip_pulses, r);
        end
        checks++;
        if (slip_count !== 3'(r)) begin
            failures++;
            $display("FAIL slip_count r=%0d: got %0d required %0d", r, slip_count, r);
        end
        checks++;
        if (r > 1 && min_gap < 5) begin
            failures++;
            $display("FAIL slip_spacing r=%0d: got %0d required >=5", r, min_gap);
        end
        checks++;
        if (err_count !== 16'(exp_err(0))) begin
            failures++;
            $display("FAIL slip_no_err: got %0d required 0", err_count);
        end
    endtask

    task automatic test_isolated_errors();
        int n, gap;
        bit dropped;
        lock_link(n);
        dropped = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rx_data = bad_word();
            step();
            if (!aligned) dropped = 1'b1;
            gap = $urandom_range(1, 4);
            rx_data = PAT;
            for (int g = 0; g < gap; g++) begin
                step();
                if (!aligned) dropped = 1'b1;
            end
        end
        for (int g = 0; g < 3; g++) begin
            step();
            if (!aligned) dropped = 1'b1;
        end
        checks++;
        if (err_count !== 16'(exp_err(3))) begin
            failures++;
            $display("FAIL iso_err_count: got %0d required %0d", err_count, exp_err(3));
        end
        checks++;
        if (err_pulses != exp_err(3)) begin
            failures++;
            $display("FAIL iso_err_pulses: got %0d required %0d", err_pulses, exp_err(3));
        end
        checks++;
        if (dropped || slip_pulses != 0) begin
            failures++;
            $display("FAIL iso_aligned: got dropped=%0d slips=%0d required 0 0", dropped, slip_pulses);
        end
    endtask

    // Ends with the FSM in its SLIP cycle so reset can be applied during the pulse.
    task automatic test_loss();
        int n;
        lock_link(n);
        rx_data = bad_word();
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (aligned !== 1'b1) begin
            failures++;
            $display("FAIL loss_early: got aligned=%b required 1", aligned);
        end
        step();
        checks++;
        if (aligned !== 1'b0 || locked_led !== 1'b1 || err_count !== 16'(exp_err(4))) begin
            failures++;
            $display("FAIL loss_drop: got al=%b led=%b ec=%0d required 0 1 %0d",
                     aligned, locked_led, err_count, exp_err(4));
        end
        step();
        checks++;
        if (bitslip !== 1'b1 || err_count !== 16'(exp_err(4)) || err_pulses != exp_err(4)) begin
            failures++;
            $display("FAIL loss_slip: got bs=%b ec=%0d pulses=%0d required 1 %0d %0d",
                     bitslip, err_count, err_pulses, exp_err(4), exp_err(4));
        end
    endtask

    task automatic test_reset_midslip();
        rst = 1'b1;
        #1;
        checks++;
        if (bitslip !== 1'b0 || aligned !== 1'b0 || slip_count !== 3'd0 ||
            err_count !== 16'h0000 || s_err_count !== 4'h0 || locked_led !== 1'b1) begin
            failures++;
            $display("FAIL reset_midslip: got bs=%b al=%b sc=%0d ec=%0d sec=%0d led=%b required 0 0 0 0 0 1",
                     bitslip, aligned, slip_count, err_count, s_err_count, locked_led);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        logic last_pulse;
        lock_link(n);
        last_pulse = 1'b0;
        for (int k = 0; k < 18; k++) begin
            rx_data = bad_word();
            step();
            rx_data = PAT;
            step();
            if (k == 17) last_pulse = s_err_pulse;
        end
        step();
        step();
        checks++;
        if (s_err_count !== 4'(exp_sat(18))) begin
            failures++;
            $display("FAIL sat_count: got %0d required %0d", s_err_count, exp_sat(18));
        end
        checks++;
        if (err_count !== 16'(exp_err(18))) begin
            failures++;
            $display("FAIL sat_wide_count: got %0d required %0d", err_count, exp_err(18));
        end
        checks++;
        if (sat_pulses != exp_err(18) || last_pulse !== 1'(ERR_EN)) begin
            failures++;
            $display("FAIL sat_pulse: got pulses=%0d last=%b required %0d %b",
                     sat_pulses, last_pulse, exp_err(18), ERR_EN);
        end
        checks++;
        if (aligned !== 1'b1 || s_aligned !== 1'b1) begin
            failures++;
            $display("FAIL sat_aligned: got %b %b required 1 1", aligned, s_aligned);
        end
    endtask

    initial begin
        cycle = 0;
        clear_counts();
        test_reset();
        test_lock_constant();
        test_slip(3);
        test_slip($urandom_range(1, 7));
        test_isolated_errors();
        test_loss();
        test_reset_midslip();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iserdes_align_checker.md
# iserdes_align_checker

Receive-side companion to the OSERDESE2 8:1 DDR pattern test. Sits in the ISERDESE2 CLKDIV domain, consumes the 8-bit parallel word from a master ISERDESE2 and drives its BITSLIP input until the word matches a known training pattern. Once locked, it checks every word, counts errors and drives status LEDs. Pure single-clock fabric logic; the ISERDESE2 and clocking live outside.

## Interface
- PATTERN, 8'h53, expected word; bit 0 = first bit on the wire (D1=1,D2=1,D3=0,D4=0,D5=1,D6=0,D7=1,D8=0).
- MATCH_COUNT, 16, consecutive matching words required to declare lock (2..255).
- LOSS_COUNT, 4, consecutive mismatches in LOCKED that force re-search (1..255).
- SETTLE_CYCLES, 3, idle cycles after a bitslip pulse before comparing (≥2, ISERDESE2 requirement).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  CLKDIV-rate clock, same clock as ISERDESE2 CLKDIV.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  ISERDESE2 Q word, bit 0 = earliest bit.
- bitslip  out  1  one-cycle pulse to ISERDESE2 BITSLIP.
- aligned  out  1  high while in LOCKED.
- slip_count  out  3  number of slips issued, modulo 8.
- err_count  out  ERR_W  saturating count of mismatched words while LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched word while LOCKED.
- locked_led  out  1  ~aligned (board LEDs active-low).

## Operation
- rx_data is registered once (rx_q); all comparisons use rx_q.
- States: SEARCH, SLIP, SETTLE, LOCKED.
- SEARCH: rx_q == PATTERN → match_cnt++; match_cnt reaching MATCH_COUNT → LOCKED, match_cnt cleared. Mismatch → SLIP, match_cnt cleared.
- SLIP: bitslip=1 for exactly this cycle, slip_count increments (wraps 7→0), → SETTLE with settle counter loaded to SETTLE_CYCLES.
- SETTLE: ignore rx_q, count down; at zero → SEARCH.
- LOCKED: match → miss_cnt cleared. Mismatch → err_pulse=1, err_count++ (saturate at all-ones, never wrap), miss_cnt++; miss_cnt reaching LOSS_COUNT → SEARCH (aligned drops, match_cnt and miss_cnt cleared; err_count retained).
- Errors are counted only in LOCKED; mismatches in SEARCH/SETTLE never touch err_count.
- No search timeout: the FSM cycles SEARCH→SLIP→SETTLE indefinitely on a dead link.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): state=SEARCH, rx_q=0, bitslip=0, aligned=0, slip_count=0, err_count=0, err_pulse=0, locked_led=1, all internal counters 0.
- Word on rx_data at edge k is in rx_q after edge k; FSM/outputs update at edge k+1 (2-cycle input-to-output latency).
- aligned rises at edge k+1 where k captured the MATCH_COUNT-th consecutive match.
- bitslip is a registered output, high for one clk period; next bitslip no earlier than SETTLE_CYCLES+2 cycles later.
- err_pulse and err_count update on the same edge.
- Reset asserted mid-operation (including during a bitslip pulse): outputs go to reset values immediately, without waiting for clk.

## Configuration
- ISERDES_CHECK_ERRCNT_EN defined: err_count and err_pulse behave as above.
- Not defined: counter logic is compiled out; err_count tied to 0, err_pulse tied to 0; lock/loss behaviour unchanged (miss_cnt still present).

## Structure
- Shared package iserdes_check_pkg: state enum (SEARCH, SLIP, SETTLE, LOCKED), default PATTERN constant 8'h53, counter width helpers.
- Single module; no sub-module needed. The saturating counter is inline.

## Test plan
- Reset then rx_data constant 8'h53 → aligned rises 17 cycles after first sampled word, bitslip never pulses, slip_count=0.
- Feed 8'h53 rotated by 3 bits, bench model rotates back one bit per bitslip pulse → exactly 3 bitslip pulses spaced ≥5 cycles, slip_count=3, then aligned after 16 matches.
- Locked, inject 3 isolated bad words separated by good words → err_count=3, three err_pulse cycles, aligned stays 1.
- Locked, inject 4 consecutive bad words → err_count=4, aligned falls on edge after 4th bad word sampled, FSM issues bitslip next.
- Force err_count to all-ones then inject a bad word → err_count stays 16'hFFFF, err_pulse still fires.
- Assert rst during SLIP cycle → bitslip=0, aligned=0, slip_count=0, err_count=0 immediately without a clk edge; with ISERDES_CHECK_ERRCNT_EN undefined, err_count stays 0 throughout all above.
